// File: rtl/adc_avg_sequencer.sv
// Sequences the three-channel ADC averager and streams each averaged result
// as a 3-beat frame (ch1, ch2, ch3 + TLAST), with single-shot and continuous runs.
module adc_avg_sequencer #(
    parameter int MIN_PERIOD = 129,
    parameter int FCNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              START,
    input  logic              STOP,
    input  logic              MODE_CONT,
    input  logic [30:0]       PERIOD_CFG,
    input  logic [FCNT_W-1:0] NUM_FRAMES,
    output logic              AVG_ENABLE,
    output logic [30:0]       AVG_COMPARE,
    input  logic [1:0]        AVG_NEW_DATA,
    input  logic [31:0]       AVG_CH1,
    input  logic [31:0]       AVG_CH2,
    input  logic [31:0]       AVG_CH3,
    output logic [31:0]       M_TDATA,
    output logic              M_TVALID,
    input  logic              M_TREADY,
    output logic              M_TLAST,
    output logic              BUSY,
    output logic              OVERRUN,
    output logic [FCNT_W-1:0] FRAME_CNT
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    localparam logic [30:0]       MIN_CMP  = 31'(MIN_PERIOD);
    localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              mode_cont;
    logic [FCNT_W-1:0] target;
    logic [FCNT_W-1:0] cap_cnt;
    logic [1:0]        last_nd;
    logic              hold_valid;
    logic [2:0][31:0]  hold_data;
    logic [2:0][31:0]  send_data;
    logic [1:0]        beat_idx;

    logic beat_accept;
    logic last_accept;
    logic send_free;
    logic hold_take;
    logic cap_done;
    logic capture;
    logic hold_store;

    assign beat_accept = M_TVALID & M_TREADY;
    assign last_accept = beat_accept & (beat_idx == 2'd2);
    // The sender reloads on the edge its last beat leaves, so frames go out back to back.
    assign send_free   = !M_TVALID | last_accept;
    assign hold_take   = hold_valid & send_free;
    assign cap_done    = !mode_cont && (cap_cnt == target);
    assign capture     = (state == RUN) && !cap_done && (AVG_NEW_DATA != last_nd);
    assign hold_store  = capture && (!hold_valid || hold_take);

    assign M_TDATA = send_data[beat_idx];
    assign M_TLAST = M_TVALID & (beat_idx == 2'd2);
    assign BUSY    = (state != IDLE);

    // NOTE: every register here is written with <= so all of them see pre-edge values;
    // a blocking update would leak into the same-edge decisions below.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= IDLE;
            AVG_ENABLE  <= 1'b0;
            AVG_COMPARE <= '0;
            mode_cont   <= 1'b0;
            target      <= '0;
            cap_cnt     <= '0;
            last_nd     <= '0;
            OVERRUN     <= 1'b0;
            FRAME_CNT   <= '0;
            hold_valid  <= 1'b0;
            // NOTE: the data buffers are reset too, because M_TDATA is read straight
            // out of send_data and must be 0 while reset is asserted.
            hold_data   <= '0;
            send_data   <= '0;
            beat_idx    <= '0;
            M_TVALID    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    AVG_ENABLE <= 1'b0;
                    if (START && !STOP) begin
                        AVG_COMPARE <= (PERIOD_CFG < MIN_CMP) ? MIN_CMP : PERIOD_CFG;
                        mode_cont   <= MODE_CONT;
                        target      <= (NUM_FRAMES == '0) ? FCNT_ONE : NUM_FRAMES;
                        OVERRUN     <= 1'b0;
                        FRAME_CNT   <= '0;
                        cap_cnt     <= '0;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    // The averager holds NEW_DATA at 0 while disabled.
                    AVG_ENABLE <= 1'b1;
                    last_nd    <= '0;
                    state      <= RUN;
                end
                RUN: begin
                    if (STOP || cap_done) begin
                        AVG_ENABLE <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    AVG_ENABLE <= 1'b0;
                    if (!hold_valid && !M_TVALID) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (capture) begin
                last_nd <= AVG_NEW_DATA;
                cap_cnt <= cap_cnt + FCNT_ONE;
                if (hold_store) hold_data <= {AVG_CH3, AVG_CH2, AVG_CH1};
                else            OVERRUN   <= 1'b1;
            end

            if (hold_store)     hold_valid <= 1'b1;
            else if (hold_take) hold_valid <= 1'b0;

            if (hold_take) begin
                send_data <= hold_data;
                beat_idx  <= '0;
                M_TVALID  <= 1'b1;
            end else if (last_accept) begin
                M_TVALID  <= 1'b0;
                beat_idx  <= '0;
            end else if (beat_accept) begin
                beat_idx  <= beat_idx + 2'd1;
            end

            if (last_accept) FRAME_CNT <= FRAME_CNT + FCNT_ONE;
        end
    end

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Directed bench for adc_avg_sequencer: the bench plays the averager and checks the
// stream against a queue of expected frames on every cycle.
module tb_adc_avg_sequencer;

    logic        CLK;
    logic        RESETN;
    logic        START;
    logic        STOP;
    logic        MODE_CONT;
    logic [30:0] PERIOD_CFG;
    logic [15:0] NUM_FRAMES;
    logic        AVG_ENABLE;
    logic [30:0] AVG_COMPARE;
    logic [1:0]  AVG_NEW_DATA;
    logic [31:0] AVG_CH1;
    logic [31:0] AVG_CH2;
    logic [31:0] AVG_CH3;
    logic [31:0] M_TDATA;
    logic        M_TVALID;
    logic        M_TREADY;
    logic        M_TLAST;
    logic        BUSY;
    logic        OVERRUN;
    logic [15:0] FRAME_CNT;

    adc_avg_sequencer dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .START       (START),
        .STOP        (STOP),
        .MODE_CONT   (MODE_CONT),
        .PERIOD_CFG  (PERIOD_CFG),
        .NUM_FRAMES  (NUM_FRAMES),
        .AVG_ENABLE  (AVG_ENABLE),
        .AVG_COMPARE (AVG_COMPARE),
        .AVG_NEW_DATA(AVG_NEW_DATA),
        .AVG_CH1     (AVG_CH1),
        .AVG_CH2     (AVG_CH2),
        .AVG_CH3     (AVG_CH3),
        .M_TDATA     (M_TDATA),
        .M_TVALID    (M_TVALID),
        .M_TREADY    (M_TREADY),
        .M_TLAST     (M_TLAST),
        .BUSY        (BUSY),
        .OVERRUN     (OVERRUN),
        .FRAME_CNT   (FRAME_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Frames that must appear on the stream, in order; element [0] is ch1.
    logic [2:0][31:0] exp_q[$];
    logic [15:0]      model_frames = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream monitor: sampled on the falling edge, half a cycle from any DUT update.
    int          beat_i = 0;
    logic        stalled = 1'b0;
    logic [31:0] stalled_data = '0;

    always @(negedge CLK) begin
        if (!RESETN) begin
            beat_i  = 0;
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(M_TVALID), 32'd1);
                check("stall_data", M_TDATA, stalled_data);
            end
            check("frame_cnt", 32'(FRAME_CNT), 32'(model_frames));
            if (M_TVALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(M_TVALID), 32'd0);
                end else begin
                    check("tdata", M_TDATA, exp_q[0][beat_i]);
                    check("tlast", 32'(M_TLAST), 32'(beat_i == 2));
                end
            end else begin
                check("tlast_idle", 32'(M_TLAST), 32'd0);
            end
            if (M_TVALID && M_TREADY && exp_q.size() != 0) begin
                if (beat_i == 2) begin
                    void'(exp_q.pop_front());
                    beat_i = 0;
                    model_frames = model_frames + 16'd1;
                end else begin
                    beat_i++;
                end
            end
            stalled      = M_TVALID && !M_TREADY;
            stalled_data = M_TDATA;
        end
    end

    task automatic start_run(input logic mode, input logic [30:0] period,
                             input logic [15:0] num, input logic [30:0] exp_cmp);
        AVG_NEW_DATA = 2'd0;
        @(posedge CLK); #1;
        START = 1'b1; MODE_CONT = mode; PERIOD_CFG = period; NUM_FRAMES = num;
        @(posedge CLK); #1;
        START = 1'b0;
        model_frames = '0;
        @(posedge CLK); #1;
        check("arm_compare", 32'(AVG_COMPARE), 32'(exp_cmp));
        check("arm_enable", 32'(AVG_ENABLE), 32'd1);
        check("arm_busy", 32'(BUSY), 32'd1);
    endtask

    // Emulates one averager result: counter and channel data change together.
    task automatic produce(input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3,
                           input logic expect_out, input int gap);
        @(posedge CLK); #1;
        AVG_NEW_DATA = AVG_NEW_DATA + 2'd1;
        AVG_CH1 = c1; AVG_CH2 = c2; AVG_CH3 = c3;
        if (expect_out) exp_q.push_back({c3, c2, c1});
        repeat (gap) @(posedge CLK);
        #1;
    endtask

    task automatic stop_run();
        @(posedge CLK); #1;
        STOP = 1'b1;
        @(posedge CLK); #1;
        STOP = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 2000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("idle_timeout", 32'(BUSY), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!M_TVALID && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("valid_timeout", 32'(M_TVALID), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, 32'(M_TVALID), 32'd0);
        check({tag, "_tlast"}, 32'(M_TLAST), 32'd0);
        check({tag, "_tdata"}, M_TDATA, 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_enable"}, 32'(AVG_ENABLE), 32'd0);
        check({tag, "_compare"}, 32'(AVG_COMPARE), 32'd0);
        check({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
        check({tag, "_frame_cnt"}, 32'(FRAME_CNT), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        START = 1'b0; STOP = 1'b0; MODE_CONT = 1'b0; PERIOD_CFG = '0; NUM_FRAMES = '0;
        AVG_NEW_DATA = '0; AVG_CH1 = '0; AVG_CH2 = '0; AVG_CH3 = '0; M_TREADY = 1'b1;
        RESETN = 1'b1;
        #3 RESETN = 1'b0;
        #2 check_all_zero("reset");
        repeat (2) @(posedge CLK);
        #1 RESETN = 1'b1;

        // Single-shot, two frames, sink always ready.
        start_run(1'b0, 31'd200, 16'd2, 31'd200);
        produce(32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 1'b1, 20);
        produce(32'h1111_0002, 32'h2222_0002, 32'h3333_0002, 1'b1, 20);
        wait_idle();
        check("ss2_frames", 32'(FRAME_CNT), 32'd2);
        check("ss2_enable_off", 32'(AVG_ENABLE), 32'd0);

        // Short period clamps; NUM_FRAMES = 0 means exactly one frame.
        start_run(1'b0, 31'd50, 16'd0, 31'd129);
        produce(32'hA0A0_0001, 32'hB0B0_0001, 32'hC0C0_0001, 1'b1, 20);
        produce(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 1'b0, 20);
        wait_idle();
        check("ss0_frames", 32'(FRAME_CNT), 32'd1);

        // Continuous with a stalled sink: third result is dropped.
        start_run(1'b1, 31'd300, 16'd5, 31'd300);
        M_TREADY = 1'b0;
        produce(32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, 1'b1, 20);
        produce(32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3, 1'b1, 20);
        check("ovr_before", 32'(OVERRUN), 32'd0);
        produce(32'h0000_00C1, 32'h0000_00C2, 32'h0000_00C3, 1'b0, 20);
        check("ovr_set", 32'(OVERRUN), 32'd1);
        check("ovr_first_beat", M_TDATA, 32'h0000_00A1);
        M_TREADY = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        stop_run();
        wait_idle();
        check("ovr_frames", 32'(FRAME_CNT), 32'd2);
        check("ovr_sticky", 32'(OVERRUN), 32'd1);

        // Continuous, STOP on the cycle the first beat is accepted.
        start_run(1'b1, 31'd150, 16'd0, 31'd150);
        M_TREADY = 1'b0;
        produce(32'h0000_00D1, 32'h0000_00D2, 32'h0000_00D3, 1'b1, 5);
        produce(32'h0000_00E1, 32'h0000_00E2, 32'h0000_00E3, 1'b1, 5);
        wait_valid();
        M_TREADY = 1'b1; STOP = 1'b1;
        @(posedge CLK); #1;
        M_TREADY = 1'b0; STOP = 1'b0;
        check("stop_enable_off", 32'(AVG_ENABLE), 32'd0);
        check("stop_still_busy", 32'(BUSY), 32'd1);
        check("stop_beat1", M_TDATA, 32'h0000_00D2);
        repeat (4) @(posedge CLK);
        #1 M_TREADY = 1'b1;
        wait_idle();
        check("stop_frames", 32'(FRAME_CNT), 32'd2);

        // NEW_DATA walks 1, 2, 3, 0: the wrap is a change like any other.
        start_run(1'b1, 31'd129, 16'd0, 31'd129);
        for (int i = 1; i <= 4; i++)
            produce(32'h5000_0000 + i, 32'h6000_0000 + i, 32'h7000_0000 + i, 1'b1, 10);
        check("wrap_nd_value", 32'(AVG_NEW_DATA), 32'd0);
        stop_run();
        wait_idle();
        check("wrap_frames", 32'(FRAME_CNT), 32'd4);

        // Asynchronous reset while the ch3 beat is waiting.
        start_run(1'b1, 31'd200, 16'd0, 31'd200);
        M_TREADY = 1'b0;
        produce(32'h0000_00F1, 32'h0000_00F2, 32'h0000_00F3, 1'b1, 3);
        M_TREADY = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        M_TREADY = 1'b0;
        check("rst_pre_valid", 32'(M_TVALID), 32'd1);
        check("rst_pre_last", 32'(M_TLAST), 32'd1);
        check("rst_pre_data", M_TDATA, 32'h0000_00F3);
        RESETN = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        model_frames = '0;
        AVG_NEW_DATA = '0;
        M_TREADY = 1'b1;
        @(posedge CLK); #1;
        RESETN = 1'b1;
        start_run(1'b0, 31'd180, 16'd1, 31'd180);
        check("post_rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
        produce(32'h0000_0071, 32'h0000_0072, 32'h0000_0073, 1'b1, 10);
        wait_idle();
        check("post_rst_frames", 32'(FRAME_CNT), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_avg_sequencer.md
Name: adc_avg_sequencer

Overview:
- Controls the three-channel ADC averaging block and moves its results onto a stream.
- Programs the averager's window and enable, and detects each new averaged result from the change of its 2-bit NEW_DATA counter.
- Captures the three channel averages and serialises them as 3-beat AXI-Stream-style frames (ch1, ch2, ch3 + TLAST).
- Supports single-shot N-frame runs and continuous runs, with overrun detection.

Parameters:
MIN_PERIOD, 129, minimum AVG_COMPARE; lower PERIOD_CFG values are clamped to this (the averager needs 129 cycles to accumulate and divide).
FCNT_W, 16, width of frame counters and NUM_FRAMES.

Ports:
CLK  in  1  system clock, rising edge
RESETN  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse; begins a run when in IDLE
STOP  in  1  one-cycle pulse; ends a run gracefully
MODE_CONT  in  1  1 = continuous, 0 = single-shot; sampled on START
PERIOD_CFG  in  31  averager period in cycles; sampled on START
NUM_FRAMES  in  FCNT_W  frames per single-shot run; sampled on START
AVG_ENABLE  out  1  enable to averager
AVG_COMPARE  out  31  period to averager
AVG_NEW_DATA  in  2  averager result counter
AVG_CH1  in  32  averager channel 1 result
AVG_CH2  in  32  averager channel 2 result
AVG_CH3  in  32  averager channel 3 result
M_TDATA  out  32  stream data
M_TVALID  out  1  stream valid
M_TREADY  in  1  stream ready
M_TLAST  out  1  high on the ch3 beat
BUSY  out  1  state != IDLE
OVERRUN  out  1  sticky; a result was dropped
FRAME_CNT  out  FCNT_W  frames fully sent in the current run

Behaviour:
- Reset values: all outputs 0, state IDLE, hold and send buffers empty, last_nd = 0.
- States:
  - IDLE: AVG_ENABLE = 0.
    - START & !STOP: latch AVG_COMPARE = max(PERIOD_CFG, MIN_PERIOD); latch mode; target = (NUM_FRAMES == 0) ? 1 : NUM_FRAMES; clear OVERRUN, FRAME_CNT and the capture count; go to ARM.
    - START & STOP in the same cycle: stay in IDLE.
  - ARM: one cycle; AVG_ENABLE = 1 registered; last_nd <= 0 (the averager holds NEW_DATA at 0 while disabled); go to RUN.
  - RUN: AVG_ENABLE = 1.
    - STOP, or (single-shot & capture count == target): go to DRAIN; AVG_ENABLE = 0 from the next cycle.
  - DRAIN: AVG_ENABLE = 0; no new captures. When the hold buffer is empty and the sender is idle, go to IDLE.
  - START outside IDLE is ignored. STOP in IDLE is ignored.
- Capture (RUN only):
  - Triggered when AVG_NEW_DATA != last_nd. Then last_nd <= AVG_NEW_DATA; the capture count increments.
  - The channel data is valid in the same cycle, because the averager registers NEW_DATA and its outputs together.
  - If the hold buffer is free, or is being emptied on this edge: store CH1..CH3 in the hold buffer.
  - Otherwise: drop the new result, set OVERRUN, and keep the older held result. The capture count still increments.
  - Wrap-around of the 2-bit counter (3 -> 0) is a change like any other.
- Sender:
  - Loads from the hold buffer when idle, or on the same edge its last beat is accepted (no bubble). Beat index 0 -> 1 -> 2.
  - M_TDATA = ch1, ch2, ch3; M_TLAST = 1 only on index 2.
  - A beat transfers on M_TVALID & M_TREADY.
  - M_TVALID never drops and M_TDATA never changes while a beat is not accepted.
- Latency: new-data change sampled at edge E0 -> hold valid after E0 -> M_TVALID = 1 after E1 (sender idle).
- FRAME_CNT increments on acceptance of a TLAST beat and wraps at 2^FCNT_W. It holds its value in IDLE until the next START.
- Single-shot termination counts captures, not sends. Frames already captured are always fully sent in DRAIN, never truncated.
- An asynchronous RESETN assertion mid-frame aborts everything to the reset values. A partial frame is lost.

Test Plan:
- Reset, then single-shot START, PERIOD_CFG = 200, NUM_FRAMES = 2, M_TREADY = 1:
  - AVG_COMPARE = 200 and AVG_ENABLE = 1 two cycles after START.
  - Two frames sent: ch1, ch2, ch3 with TLAST on the third beat.
  - FRAME_CNT = 2, then BUSY = 0.
- PERIOD_CFG = 50 -> AVG_COMPARE = 129.
- Single-shot with NUM_FRAMES = 0 -> exactly 1 frame is sent.
- Continuous mode, M_TREADY = 0 for 3 periods:
  - First frame sits in send, second in hold, third is dropped; OVERRUN = 1.
  - After M_TREADY = 1, the first two frames emerge intact, with M_TDATA stable while stalled.
- Continuous mode, STOP mid-frame (beat 1 of 3 accepted):
  - AVG_ENABLE = 0 next cycle.
  - The remaining 2 beats and any held frame are still sent, then IDLE.
- NEW_DATA sequence 3 -> 0 across periods -> each change captured; FRAME_CNT counts 4 over values 1, 2, 3, 0.
- RESETN low during beat 2 with M_TVALID = 1:
  - All outputs 0 immediately.
  - After release, a new START runs cleanly with FRAME_CNT starting at 0.
